// File: rtl/voice_phase_pkg.sv
// Shared types for the voice phase scheduler: FSM state encoding and
// voice index sizing.
package voice_phase_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    localparam int DEFAULT_N_VOICES = 4;

    // Width of a voice index; never narrower than one bit.
    function automatic int voice_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [voice_w(DEFAULT_N_VOICES)-1:0] voice_idx_t;

endpackage

// File: rtl/voice_state_regfile.sv
// Per-voice storage of FCW, gate and phase, with one combinational read
// port, one phase update port and one config write port.
module voice_state_regfile
    import voice_phase_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int N_VOICES    = 4,
    parameter int VOICE_W     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VOICE_W-1:0]     rd_idx,
    output logic [PHASE_WIDTH-1:0] rd_fcw,
    output logic [PHASE_WIDTH-1:0] rd_phase,
    output logic                   rd_gate,
    input  logic                   upd_en,
    input  logic [VOICE_W-1:0]     upd_idx,
    input  logic [PHASE_WIDTH-1:0] upd_phase,
    input  logic                   cfg_en,
    input  logic [VOICE_W-1:0]     cfg_voice,
    input  logic [PHASE_WIDTH-1:0] cfg_fcw,
    input  logic                   cfg_gate
);

    logic [PHASE_WIDTH-1:0] fcw_q   [N_VOICES];
    logic [PHASE_WIDTH-1:0] phase_q [N_VOICES];
    logic [N_VOICES-1:0]    gate_q;

    // Decoded read so an index past the last voice simply reads zero.
    always_comb begin
        rd_fcw   = '0;
        rd_phase = '0;
        rd_gate  = 1'b0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (rd_idx == VOICE_W'(v)) begin
                rd_fcw   = fcw_q[v];
                rd_phase = phase_q[v];
                rd_gate  = gate_q[v];
            end
        end
    end

    // A config write matching no entry is dropped; config beats update on a clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q <= '0;
            for (int v = 0; v < N_VOICES; v++) begin
                fcw_q[v]   <= '0;
                phase_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < N_VOICES; v++) begin
                if (cfg_en && (cfg_voice == VOICE_W'(v))) begin
                    fcw_q[v]  <= cfg_fcw;
                    gate_q[v] <= cfg_gate;
                    if (!gate_q[v] && cfg_gate) begin
                        phase_q[v] <= '0;
                    end
                end else if (upd_en && (upd_idx == VOICE_W'(v))) begin
                    phase_q[v] <= upd_phase;
                end
            end
        end
    end

endmodule

// File: rtl/voice_phase_scheduler.sv
// Round-robin phase accumulator: one shared adder advances every voice once
// per sample_tick and streams the new phases out through a two-stage pipe.
module voice_phase_scheduler
    import voice_phase_pkg::*;
#(
    parameter  int PHASE_WIDTH = 32,
    parameter  int N_VOICES    = 4,
    localparam int VOICE_W     = voice_w(N_VOICES)
) (
    input  logic                   clk,
    input  logic                   rst_active_high,
    input  logic                   sample_tick,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [VOICE_W-1:0]     cfg_voice,
    input  logic [PHASE_WIDTH-1:0] cfg_fcw,
    input  logic                   cfg_gate,
    input  logic                   overrun_clear,
    output logic                   busy,
    output logic                   phase_valid,
    output logic [VOICE_W-1:0]     phase_voice,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic                   phase_active,
    output logic                   overrun
);

    localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(N_VOICES - 1);

    // Config handshake: a write transfers on cfg_valid && cfg_ready; cfg_ready
    // is low for the whole update round, so a held request waits without loss.

    state_t                 state;
    logic [VOICE_W-1:0]     idx;
    logic [PHASE_WIDTH-1:0] rd_fcw;
    logic [PHASE_WIDTH-1:0] rd_phase;
    logic                   rd_gate;
    logic [PHASE_WIDTH-1:0] sum;
    logic                   upd_en;
    logic                   cfg_fire;

    logic                   s1_valid;
    logic [VOICE_W-1:0]     s1_voice;
    logic [PHASE_WIDTH-1:0] s1_phase;
    logic                   s1_active;

    assign busy      = (state == UPDATE);
    assign cfg_ready = !busy;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign upd_en    = (state == UPDATE);
    assign sum       = rd_phase + (rd_gate ? rd_fcw : '0);

    voice_state_regfile #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .N_VOICES    (N_VOICES),
        .VOICE_W     (VOICE_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst_active_high),
        .rd_idx    (idx),
        .rd_fcw    (rd_fcw),
        .rd_phase  (rd_phase),
        .rd_gate   (rd_gate),
        .upd_en    (upd_en),
        .upd_idx   (idx),
        .upd_phase (sum),
        .cfg_en    (cfg_fire),
        .cfg_voice (cfg_voice),
        .cfg_fcw   (cfg_fcw),
        .cfg_gate  (cfg_gate)
    );

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            state        <= IDLE;
            idx          <= '0;
            overrun      <= 1'b0;
            s1_valid     <= 1'b0;
            s1_voice     <= '0;
            s1_phase     <= '0;
            s1_active    <= 1'b0;
            phase_valid  <= 1'b0;
            phase_voice  <= '0;
            phase_out    <= '0;
            phase_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= UPDATE;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + VOICE_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // A tick landing mid-round is lost; setting beats clearing.
            if (sample_tick && (state == UPDATE)) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end

            s1_valid  <= upd_en;
            s1_voice  <= idx;
            s1_phase  <= sum;
            s1_active <= rd_gate;

            phase_valid  <= s1_valid;
            phase_voice  <= s1_voice;
            phase_out    <= s1_phase;
            phase_active <= s1_active;
        end
    end

endmodule

// File: tb/tb_voice_phase_scheduler.sv
// Directed bench for voice_phase_scheduler: a reference model of the voice
// table predicts every strobe (cycle, voice, gate, phase) of each round.
module tb_voice_phase_scheduler;

    localparam int PW = 32;
    localparam int NV = 4;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_tick = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [VW-1:0] cfg_voice = '0;
    logic [PW-1:0] cfg_fcw = '0;
    logic          cfg_gate = 1'b0;
    logic          overrun_clear = 1'b0;
    logic          busy;
    logic          phase_valid;
    logic [VW-1:0] phase_voice;
    logic [PW-1:0] phase_out;
    logic          phase_active;
    logic          overrun;

    voice_phase_scheduler #(.PHASE_WIDTH(PW), .N_VOICES(NV)) dut (
        .clk             (clk),
        .rst_active_high (rst),
        .sample_tick     (sample_tick),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_voice       (cfg_voice),
        .cfg_fcw         (cfg_fcw),
        .cfg_gate        (cfg_gate),
        .overrun_clear   (overrun_clear),
        .busy            (busy),
        .phase_valid     (phase_valid),
        .phase_voice     (phase_voice),
        .phase_out       (phase_out),
        .phase_active    (phase_active),
        .overrun         (overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: entry = {cycle[15:0], voice[7:0], active, phase[31:0]}
    logic [56:0] exp_q[$];
    logic [56:0] got_q[$];
    logic [PW-1:0] m_fcw   [NV];
    logic [PW-1:0] m_phase [NV];
    logic          m_gate  [NV];
    logic [PW-1:0] last_phase [NV];
    logic          last_active [NV];
    int n_checks = 0;
    int n_pass = 0;

    always @(negedge clk) begin
        if (phase_valid) got_q.push_back({cyc[15:0], 8'(phase_voice), phase_active, phase_out});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_fcw[v] = '0; m_phase[v] = '0; m_gate[v] = 1'b0;
            last_phase[v] = '0; last_active[v] = 1'b0;
        end
    endtask

    task automatic model_write(input int v, input logic [PW-1:0] f, input logic g);
        if (v < NV) begin
            if (!m_gate[v] && g) m_phase[v] = '0;
            m_fcw[v]  = f;
            m_gate[v] = g;
        end
    endtask

    // Voice i of a tick driven while cyc == c is seen at the negedge where cyc == c+3+i.
    task automatic model_advance(input int c, input int n_expect);
        for (int v = 0; v < NV; v++) begin
            if (m_gate[v]) m_phase[v] = m_phase[v] + m_fcw[v];
            if (v < n_expect) exp_q.push_back({16'(c + 3 + v), 8'(v), m_gate[v], m_phase[v]});
        end
    endtask

    task automatic compare_round();
        logic [56:0] g;
        logic [56:0] e;
        check("strobe_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check("strobe", 64'(g), 64'(e));
            if (int'(g[40:33]) < NV) begin
                last_phase[int'(g[40:33])]  = g[31:0];
                last_active[int'(g[40:33])] = g[32];
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // driver tasks
    task automatic cfg_write(input int v, input logic [PW-1:0] f, input logic g);
        int n = 0;
        cfg_valid = 1'b1; cfg_voice = VW'(v); cfg_fcw = f; cfg_gate = g;
        while (!cfg_ready && n < 50) begin step(); n++; end
        check("cfg_wait", 64'(n < 50), 64'(1));
        step();
        cfg_valid = 1'b0;
        model_write(v, f, g);
    endtask

    task automatic tick_round();
        int c = cyc;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        model_advance(c, NV);
        repeat (NV + 3) step();
        compare_round();
    endtask

    initial begin
        int c;
        int n;
        model_reset();
        // reset state
        #1;
        check("rst_valid", 64'(phase_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(cfg_ready), 64'(1));
        check("rst_overrun", 64'(overrun), 64'(0));
        step(); step();
        rst = 1'b0;
        step();

        // 1: single voice accumulation
        cfg_write(0, 32'h1000_0000, 1'b1);
        tick_round();
        check("t1_v0_r1", 64'(last_phase[0]), 64'h1000_0000);
        check("t1_v1_r1", 64'(last_phase[1]), 64'h0);
        check("t1_v1_act", 64'(last_active[1]), 64'h0);
        tick_round();
        check("t1_v0_r2", 64'(last_phase[0]), 64'h2000_0000);
        tick_round();
        check("t1_v0_r3", 64'(last_phase[0]), 64'h3000_0000);
        check("t1_v3_r3", 64'(last_phase[3]), 64'h0);

        // 2: wrap modulo 2^32
        cfg_write(1, 32'hC000_0000, 1'b1);
        tick_round();
        check("t2_v1_r1", 64'(last_phase[1]), 64'hC000_0000);
        tick_round();
        check("t2_v1_r2", 64'(last_phase[1]), 64'h8000_0000);

        // 3: note off holds, retrigger restarts, legato continues
        cfg_write(2, 32'h1000_0000, 1'b1);
        repeat (3) tick_round();
        check("t3_v2_base", 64'(last_phase[2]), 64'h3000_0000);
        cfg_write(2, 32'h1000_0000, 1'b0);
        tick_round();
        check("t3_v2_off", 64'(last_phase[2]), 64'h3000_0000);
        check("t3_v2_off_act", 64'(last_active[2]), 64'h0);
        cfg_write(2, 32'h1000_0000, 1'b1);
        tick_round();
        check("t3_v2_retrig", 64'(last_phase[2]), 64'h1000_0000);
        repeat (2) tick_round();
        cfg_write(2, 32'h0800_0000, 1'b1);
        tick_round();
        check("t3_v2_legato", 64'(last_phase[2]), 64'h3800_0000);

        // 4: overrun on ticks inside a round
        c = cyc; sample_tick = 1'b1; step(); sample_tick = 1'b0;
        model_advance(c, NV);
        step();
        sample_tick = 1'b1; step(); sample_tick = 1'b0;
        repeat (NV + 2) step();
        compare_round();
        check("t4_overrun", 64'(overrun), 64'(1));
        overrun_clear = 1'b1; step(); overrun_clear = 1'b0;
        check("t4_cleared", 64'(overrun), 64'(0));
        c = cyc; sample_tick = 1'b1; step(); sample_tick = 1'b0;
        model_advance(c, NV);
        repeat (NV - 1) step();
        check("t4_last_busy", 64'(busy), 64'(1));
        sample_tick = 1'b1; step(); sample_tick = 1'b0;
        repeat (NV + 2) step();
        compare_round();
        check("t4_last_drop", 64'(overrun), 64'(1));
        overrun_clear = 1'b1; step(); overrun_clear = 1'b0;
        c = cyc; sample_tick = 1'b1; step(); sample_tick = 1'b0;
        model_advance(c, NV);
        step();
        sample_tick = 1'b1; overrun_clear = 1'b1; step();
        sample_tick = 1'b0; overrun_clear = 1'b0;
        check("t4_set_wins", 64'(overrun), 64'(1));
        repeat (NV + 2) step();
        compare_round();
        overrun_clear = 1'b1; step(); overrun_clear = 1'b0;

        // 5: write held across a round, then write and tick together
        c = cyc; sample_tick = 1'b1; step(); sample_tick = 1'b0;
        model_advance(c, NV);
        step();
        check("t5_ready_busy", 64'(cfg_ready), 64'(0));
        cfg_valid = 1'b1; cfg_voice = 2'd3; cfg_fcw = 32'h0100_0000; cfg_gate = 1'b1;
        n = 0;
        while (!cfg_ready && n < 20) begin step(); n++; end
        check("t5_ready_cycle", 64'(cyc - c), 64'(NV + 1));
        c = cyc; sample_tick = 1'b1; step();
        sample_tick = 1'b0; cfg_valid = 1'b0;
        model_write(3, 32'h0100_0000, 1'b1);
        model_advance(c, NV);
        repeat (NV + 3) step();
        compare_round();
        check("t5_v3_new_fcw", 64'(last_phase[3]), 64'h0100_0000);

        // 6: reset mid-round
        c = cyc; sample_tick = 1'b1; step(); sample_tick = 1'b0;
        model_advance(c, 2);
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("t6_valid", 64'(phase_valid), 64'(0));
        check("t6_phase", 64'(phase_out), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_ready", 64'(cfg_ready), 64'(1));
        step();
        rst = 1'b0;
        repeat (NV + 3) step();
        compare_round();
        model_reset();
        cfg_write(0, 32'h0500_0000, 1'b1);
        tick_round();
        check("t6_v0_fresh", 64'(last_phase[0]), 64'h0500_0000);
        check("t6_v1_fresh", 64'(last_phase[1]), 64'h0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/voice_phase_scheduler.md
Name: voice_phase_scheduler

Overview:
- Time-multiplexes one shared PHASE_WIDTH-bit phase-accumulation adder across N_VOICES tracker voices.
- Holds each voice's frequency control word (FCW), gate and phase.
- On each sample_tick, advances all voices in order, one per cycle, and streams the updated phases to the wavetable/mixer stage.
- Sits between the pattern sequencer, which writes notes over the cfg handshake, and the per-voice waveform lookup.

Parameters:
PHASE_WIDTH, 32, width of FCW and phase words
N_VOICES, 4, number of voices; must be >= 2; need not be a power of two
VOICE_W, $clog2(N_VOICES), voice index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_active_high  in  1  asynchronous, active-high reset
sample_tick  in  1  one-cycle pulse; starts one update round
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready
cfg_voice  in  VOICE_W  target voice
cfg_fcw  in  PHASE_WIDTH  new FCW for target voice
cfg_gate  in  1  1 = note on, 0 = note off
overrun_clear  in  1  clears sticky overrun
busy  out  1  update round in progress
phase_valid  out  1  one-cycle strobe per voice result
phase_voice  out  VOICE_W  voice index of phase_out
phase_out  out  PHASE_WIDTH  updated phase of phase_voice
phase_active  out  1  gate of phase_voice at update time
overrun  out  1  sticky: a sample_tick was dropped

Behaviour:
Reset (async assert, sync deassert handled upstream):
- State IDLE; all fcw, phase and gate arrays cleared to 0.
- Outputs: phase_valid=0, phase_voice=0, phase_out=0, phase_active=0, overrun=0, busy=0, cfg_ready=1.
- Reset mid-round aborts the round immediately; no further phase_valid strobes.

FSM states: IDLE, UPDATE.
- IDLE -> UPDATE on sample_tick; idx <= 0.
- UPDATE, cycle k: idx=k, and phase[k] <= phase[k] + (gate[k] ? fcw[k] : 0), modulo 2^PHASE_WIDTH (carry discarded, wraps silently).
- UPDATE -> IDLE after idx = N_VOICES-1; otherwise idx <= idx+1.

Output timing:
- Results are registered. If the tick is sampled at edge t, voice i is strobed in the cycle after edge t+2+i.
- phase_out is the post-add value. phase_valid is high for exactly N_VOICES consecutive cycles per round.
- busy = (state == UPDATE), combinational from state. cfg_ready = !busy.

Config handshake:
- A write fires on cfg_valid && cfg_ready.
- fcw[v] <= cfg_fcw and gate[v] <= cfg_gate.
- If stored gate[v]=0 and cfg_gate=1 (retrigger): phase[v] <= 0.
- If gate 1 -> 1 (legato): phase is kept.
- If cfg_gate=0: phase is held. The voice is still strobed each round, with phase_active=0 and phase unchanged.
- cfg_voice >= N_VOICES: write is accepted (handshake completes) and discarded.

Simultaneous events:
- Write and sample_tick in the same IDLE cycle: both are taken. The round uses the newly written fcw/gate/phase.
- sample_tick while busy, including the final UPDATE cycle: tick dropped, overrun <= 1.
- overrun_clear and a dropped tick in the same cycle: set wins (overrun=1).
- cfg_valid held while busy: stalls until busy=0, with no loss of data.

Decomposition:
- Package voice_phase_pkg: state_t enum {IDLE, UPDATE}; localparam helper for VOICE_W; voice_idx_t typedef.
- One natural sub-module: voice_state_regfile, holding the fcw/phase/gate arrays. It has one read port for idx, one write port for the update, and a cfg write port. If both the cfg and update write paths target the same entry, cfg wins; this case cannot occur while the FSM is correct.
- The adder and FSM stay in the top module.

Test Plan:
1. Reset, then write v0 fcw=0x1000_0000 gate=1, then 3 ticks, each spaced ≥ N_VOICES+2 cycles. Required: v0 strobed 0x1000_0000, 0x2000_0000, 0x3000_0000; v1..v3 strobe 0 with phase_active=0.
2. Wrap: v1 fcw=0xC000_0000 gate=1, two ticks. Required: v1 phases 0xC000_0000 then 0x8000_0000.
3. Retrigger vs legato: v2 at phase 0x3000_0000. Writing gate=0 then gate=1 resets v2 to 0, so the next round gives fcw. Writing gate=1 over gate=1 continues from 0x3000_0000+fcw.
4. Overrun: tick, then a second tick 2 cycles later. Required: only 4 strobes, overrun=1. overrun_clear then sets overrun=0. Tick + overrun_clear on a dropped tick leaves overrun=1.
5. Handshake: cfg_valid asserted during a round. Required: cfg_ready=0 until the cycle after the last update state; write fires in the first IDLE cycle. Write + tick in the same cycle uses the new fcw.
6. Async reset asserted mid-round (after voice 1 strobes). Required: outputs zero immediately, no further strobes, next round starts from phase 0.
